// File: rtl/alu_op_issuer.sv
// ---------------------------------------------------------------------------
// alu_op_issuer
//
// Purpose:
//   Buffers upstream ALU commands in a small FIFO and issues them to a
//   downstream ALU one at a time. Each issued command holds CE and the
//   operand/command fields for one ISSUE cycle, then a WAIT period whose
//   length depends on the operation. Multiplies (MODE=1, CMD 9 or 10) wait
//   two cycles, and everything else waits one. The issuer never looks at
//   operand validity. A command with INP_VALID=2'b00 is issued like any other.
//
// Configuration macro:
//   ALU_ISSUE_BYPASS_EN - when defined, a command accepted while the block
//                         is idle with an empty FIFO goes straight to the
//                         output registers and enters ISSUE on the same
//                         edge. The FIFO is skipped. When undefined, every
//                         command passes through the FIFO.
//
// Parameters:
//   WIDTH      operand width in bits
//   CMD_WIDTH  command width in bits
//   DEPTH      number of FIFO entries (power of 2, >= 2)
//
// Ports:
//   CLK           in   rising-edge clock
//   RST           in   asynchronous active-low reset
//   IN_VALID      in   upstream command valid
//   IN_READY      out  FIFO has room (COUNT < DEPTH)
//   IN_OPA/OPB    in   upstream operands
//   IN_CMD        in   upstream ALU command
//   IN_MODE       in   upstream arithmetic/logic mode
//   IN_CIN        in   upstream carry-in
//   IN_INP_VALID  in   upstream operand-valid flags
//   OPA/OPB       out  operands to the ALU
//   CMD/MODE/CIN  out  controls to the ALU
//   INP_VALID     out  operand-valid flags (non-zero only during ISSUE)
//   CE            out  ALU clock enable (high in ISSUE and WAIT)
//   BUSY          out  FSM not idle or FIFO non-empty
//   COUNT         out  FIFO occupancy
// ---------------------------------------------------------------------------
module alu_op_issuer #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4,
    parameter int DEPTH     = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [WIDTH-1:0]         IN_OPA,
    input  logic [WIDTH-1:0]         IN_OPB,
    input  logic [CMD_WIDTH-1:0]     IN_CMD,
    input  logic                     IN_MODE,
    input  logic                     IN_CIN,
    input  logic [1:0]               IN_INP_VALID,
    output logic [WIDTH-1:0]         OPA,
    output logic [WIDTH-1:0]         OPB,
    output logic [CMD_WIDTH-1:0]     CMD,
    output logic                     MODE,
    output logic                     CIN,
    output logic [1:0]               INP_VALID,
    output logic                     CE,
    output logic                     BUSY,
    output logic [$clog2(DEPTH):0]   COUNT
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Elaboration-time guard. The pointers rely on natural binary wrap.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("alu_op_issuer: DEPTH must be a power of 2 and at least 2");
    end

    // One queued command, with every upstream field kept together.
    typedef struct packed {
        logic [WIDTH-1:0]     opa;
        logic [WIDTH-1:0]     opb;
        logic [CMD_WIDTH-1:0] cmd;
        logic                 mode;
        logic                 cin;
        logic [1:0]           inp_valid;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Declarations
    // -----------------------------------------------------------------------
    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    state_t             state;
    state_t             state_next;
    logic [1:0]         wait_cnt;     // remaining WAIT cycles minus one
    logic [1:0]         wait_next;

    entry_t             out_q;        // entry currently presented to the ALU
    entry_t             in_entry;

    logic               accept;
    logic               push;
    logic               pop;
`ifdef ALU_ISSUE_BYPASS_EN
    logic               load_in;      // bypass: upstream straight to outputs
`endif

    assign in_entry = '{
        opa:       IN_OPA,
        opb:       IN_OPB,
        cmd:       IN_CMD,
        mode:      IN_MODE,
        cin:       IN_CIN,
        inp_valid: IN_INP_VALID
    };

    // Ready depends only on occupancy. A pop on the same edge does not
    // open a slot early, so a full FIFO never accepts.
    assign IN_READY = (count < CNT_W'(DEPTH));
    assign accept   = IN_VALID && IN_READY;

    // Multiplies need one extra cycle of ALU time.
    function automatic logic is_mul(input entry_t e);
        return e.mode && (e.cmd == CMD_WIDTH'(9) || e.cmd == CMD_WIDTH'(10));
    endfunction

    // -----------------------------------------------------------------------
    // FSM: next state, FIFO control and wait counter
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch can be inferred.
        state_next = state;
        wait_next  = wait_cnt;
        push       = accept;
        pop        = 1'b0;
`ifdef ALU_ISSUE_BYPASS_EN
        load_in    = 1'b0;
`endif

        unique case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = S_ISSUE;
                end
`ifdef ALU_ISSUE_BYPASS_EN
                else if (accept) begin
                    // The empty FIFO is skipped. The command goes directly to the outputs.
                    push       = 1'b0;
                    load_in    = 1'b1;
                    state_next = S_ISSUE;
                end
`endif
            end

            S_ISSUE: begin
                state_next = S_WAIT;
                wait_next  = is_mul(out_q) ? 2'd1 : 2'd0;
            end

            S_WAIT: begin
                if (wait_cnt != 2'd0) begin
                    wait_next = wait_cnt - 2'd1;
                end else if (count != '0) begin
                    pop        = 1'b1;
                    state_next = S_ISSUE;
                end else begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= S_IDLE;
            wait_cnt <= 2'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO pointers, occupancy and output register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            out_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            // Push and pop on the same edge cancel out.
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (pop) begin
                out_q <= mem[rd_ptr];
            end
`ifdef ALU_ISSUE_BYPASS_EN
            else if (load_in) begin
                out_q <= in_entry;
            end
`endif
        end
    end

    // NOTE: the storage array has no reset. Entries are never read before
    // they are written, because count and the pointers are reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign OPA       = out_q.opa;
    assign OPB       = out_q.opb;
    assign CMD       = out_q.cmd;
    assign MODE      = out_q.mode;
    assign CIN       = out_q.cin;
    assign INP_VALID = (state == S_ISSUE) ? out_q.inp_valid : 2'b00;
    assign CE        = (state != S_IDLE);
    assign BUSY      = (state != S_IDLE) || (count != '0);
    assign COUNT     = count;

    // -----------------------------------------------------------------------
    // Structural invariants
    // -----------------------------------------------------------------------
    a_count_bound: assert property (@(posedge CLK) disable iff (!RST)
        count <= CNT_W'(DEPTH));
    a_no_pop_empty: assert property (@(posedge CLK) disable iff (!RST)
        !(pop && count == '0));
    a_no_push_full: assert property (@(posedge CLK) disable iff (!RST)
        !(push && count == CNT_W'(DEPTH)));

endmodule
